// File: rtl/mem_stage.sv
// Data-memory access stage: issues loads/stores on a request/ready port and retires a
// registered writeback record. Define MEM_ALIGN_CHECK_EN to reject misaligned accesses.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 3'd0
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 3'd1
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 3'd2
`endif

module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_data,
  input  logic [4:0]  ex_wb_reg,
  input  logic [31:0] ex_wb_data,
  input  logic        ex_wb_we,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        bus_err,
  output logic        align_err
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        dwe_q, dwe_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  cap_reg_q, cap_reg_d;
  logic [31:0] cap_data_q, cap_data_d;
  logic        cap_we_q, cap_we_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic        bus_err_q, bus_err_d;
  logic        align_err_d;
  logic        is_mem;
  logic        misaligned;
  logic        accept;

  assign accept = (state_q == StIdle) && ex_valid;
  assign is_mem = (ex_mem_op == `MEM_LW_OP) || (ex_mem_op == `MEM_SW_OP);

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  assign misaligned = (ex_mem_addr[1:0] != 2'b00);
  assign align_err  = align_err_q;
  always_ff @(posedge clk) begin
    if (rst) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end
`else
  assign misaligned = 1'b0;
  assign align_err  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_mem && !misaligned) state_d = StAccess;
      end
      StAccess: begin
        if (dmem_ready || (cnt_q == TimeoutLast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    req_d       = req_q;
    dwe_d       = dwe_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_reg_d   = cap_reg_q;
    cap_data_d  = cap_data_q;
    cap_we_d    = cap_we_q;
    wb_valid_d  = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    bus_err_d   = 1'b0;
    align_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cap_reg_d  = ex_wb_reg;
          cap_data_d = ex_wb_data;
          cap_we_d   = ex_wb_we;
          if (is_mem && !misaligned) begin
            cnt_d   = '0;
            req_d   = 1'b1;
            dwe_d   = (ex_mem_op == `MEM_SW_OP);
            addr_d  = ex_mem_addr;
            wdata_d = ex_mem_data;
          end else begin
            // Non-memory ops retire directly; a rejected access retires without a write.
            wb_valid_d  = 1'b1;
            wb_reg_d    = ex_wb_reg;
            wb_data_d   = ex_wb_data;
            wb_we_d     = ex_wb_we && !is_mem;
            align_err_d = is_mem;
          end
        end
      end
      StAccess: begin
        if (dmem_ready) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = cap_reg_q;
          wb_data_d  = dwe_q ? cap_data_q : dmem_rdata;
          wb_we_d    = cap_we_q;
        end else if (cnt_q == TimeoutLast) begin
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_reg_d   = cap_reg_q;
          wb_data_d  = cap_data_q;
          wb_we_d    = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      req_q      <= 1'b0;
      dwe_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cap_reg_q  <= '0;
      cap_data_q <= '0;
      cap_we_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dwe_q      <= dwe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_reg_q  <= cap_reg_d;
      cap_data_q <= cap_data_d;
      cap_we_q   <= cap_we_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Outputs: all straight from registers
  always_comb begin
    mem_stall  = (state_q == StAccess);
    dmem_req   = req_q;
    dmem_we    = dwe_q;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    wb_valid   = wb_valid_q;
    wb_reg     = wb_reg_q;
    wb_data    = wb_data_q;
    wb_we      = wb_we_q;
    bus_err    = bus_err_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): NOP, LW with wait, SW + back-to-back LW,
// timeout abort, reset mid-access, and the misalignment path.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 3'd0
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 3'd1
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 3'd2
`endif

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_data;
  logic [4:0]  ex_wb_reg;
  logic [31:0] ex_wb_data;
  logic        ex_wb_we;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        bus_err;
  logic        align_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_mem_op  (ex_mem_op),
    .ex_mem_addr(ex_mem_addr),
    .ex_mem_data(ex_mem_data),
    .ex_wb_reg  (ex_wb_reg),
    .ex_wb_data (ex_wb_data),
    .ex_wb_we   (ex_wb_we),
    .mem_stall  (mem_stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .bus_err    (bus_err),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_stall"},  32'(mem_stall),  32'h0);
    check({tag, ".dmem_req"},   32'(dmem_req),   32'h0);
    check({tag, ".dmem_we"},    32'(dmem_we),    32'h0);
    check({tag, ".dmem_addr"},  dmem_addr,       32'h0);
    check({tag, ".dmem_wdata"}, dmem_wdata,      32'h0);
    check({tag, ".wb_valid"},   32'(wb_valid),   32'h0);
    check({tag, ".wb_reg"},     32'(wb_reg),     32'h0);
    check({tag, ".wb_data"},    wb_data,         32'h0);
    check({tag, ".wb_we"},      32'(wb_we),      32'h0);
    check({tag, ".bus_err"},    32'(bus_err),    32'h0);
    check({tag, ".align_err"},  32'(align_err),  32'h0);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] mdata, input logic [4:0] r, input logic [31:0] d,
                       input logic we);
    ex_valid    = v;
    ex_mem_op   = op;
    ex_mem_addr = addr;
    ex_mem_data = mdata;
    ex_wb_reg   = r;
    ex_wb_data  = d;
    ex_wb_we    = we;
  endtask

  initial begin
    rst        = 1'b1;
    dmem_rdata = '0;
    dmem_ready = 1'b0;
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // NOP retires the next cycle
    drive(1'b1, `MEM_NOP_OP, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1);
    tick();
    check("nop.wb_valid", 32'(wb_valid), 32'h1);
    check("nop.wb_reg",   32'(wb_reg),   32'h5);
    check("nop.wb_data",  wb_data,       32'h1234);
    check("nop.wb_we",    32'(wb_we),    32'h1);
    check("nop.dmem_req", 32'(dmem_req), 32'h0);
    check("nop.stall",    32'(mem_stall), 32'h0);
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    check("idle.wb_valid", 32'(wb_valid), 32'h0);

    // LW, ready in the third request cycle
    drive(1'b1, `MEM_LW_OP, 32'h100, 32'h0, 5'd8, 32'h55, 1'b1);
    tick();
    check("lw.c1.req",   32'(dmem_req),  32'h1);
    check("lw.c1.stall", 32'(mem_stall), 32'h1);
    check("lw.c1.we",    32'(dmem_we),   32'h0);
    check("lw.c1.addr",  dmem_addr,      32'h100);
    check("lw.c1.wbv",   32'(wb_valid),  32'h0);
    tick();
    check("lw.c2.req",   32'(dmem_req),  32'h1);
    tick();
    check("lw.c3.req",   32'(dmem_req),  32'h1);
    check("lw.c3.addr",  dmem_addr,      32'h100);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ready = 1'b0;
    check("lw.done.req",   32'(dmem_req),  32'h0);
    check("lw.done.stall", 32'(mem_stall), 32'h0);
    check("lw.done.wbv",   32'(wb_valid),  32'h1);
    check("lw.done.reg",   32'(wb_reg),    32'h8);
    check("lw.done.data",  wb_data,        32'hDEADBEEF);
    check("lw.done.we",    32'(wb_we),     32'h1);
    check("lw.done.berr",  32'(bus_err),   32'h0);
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    check("lw.after.wbv", 32'(wb_valid), 32'h0);

    // SW with ready in its first request cycle, then back-to-back LW
    drive(1'b1, `MEM_SW_OP, 32'h40, 32'hCAFE0001, 5'd3, 32'h77, 1'b0);
    tick();
    check("sw.req",   32'(dmem_req), 32'h1);
    check("sw.we",    32'(dmem_we),  32'h1);
    check("sw.addr",  dmem_addr,     32'h40);
    check("sw.wdata", dmem_wdata,    32'hCAFE0001);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11111111;
    tick();
    dmem_ready = 1'b0;
    check("sw.done.req",   32'(dmem_req),  32'h0);
    check("sw.done.stall", 32'(mem_stall), 32'h0);
    check("sw.done.wbv",   32'(wb_valid),  32'h1);
    check("sw.done.reg",   32'(wb_reg),    32'h3);
    check("sw.done.data",  wb_data,        32'h77);
    check("sw.done.we",    32'(wb_we),     32'h0);
    drive(1'b1, `MEM_LW_OP, 32'h200, 32'h0, 5'd9, 32'h0, 1'b1);
    tick();
    check("b2b.req",   32'(dmem_req),  32'h1);
    check("b2b.we",    32'(dmem_we),   32'h0);
    check("b2b.addr",  dmem_addr,      32'h200);
    check("b2b.stall", 32'(mem_stall), 32'h1);
    check("b2b.wbv",   32'(wb_valid),  32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ready = 1'b0;
    check("b2b.done.wbv",  32'(wb_valid), 32'h1);
    check("b2b.done.reg",  32'(wb_reg),   32'h9);
    check("b2b.done.data", wb_data,       32'h0BADF00D);
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();

    // Timeout: ready never comes, request lasts TIMEOUT=4 cycles
    drive(1'b1, `MEM_LW_OP, 32'h300, 32'h0, 5'd10, 32'hAA, 1'b1);
    tick();
    check("to.c1.req", 32'(dmem_req), 32'h1);
    tick();
    check("to.c2.req", 32'(dmem_req), 32'h1);
    tick();
    check("to.c3.req", 32'(dmem_req), 32'h1);
    tick();
    check("to.c4.req",  32'(dmem_req), 32'h1);
    check("to.c4.berr", 32'(bus_err),  32'h0);
    check("to.c4.wbv",  32'(wb_valid), 32'h0);
    tick();
    check("to.abort.req",   32'(dmem_req),  32'h0);
    check("to.abort.stall", 32'(mem_stall), 32'h0);
    check("to.abort.berr",  32'(bus_err),   32'h1);
    check("to.abort.wbv",   32'(wb_valid),  32'h1);
    check("to.abort.we",    32'(wb_we),     32'h0);
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    check("to.after.berr", 32'(bus_err),  32'h0);
    check("to.after.wbv",  32'(wb_valid), 32'h0);

    // Reset in the middle of an access
    drive(1'b1, `MEM_LW_OP, 32'h400, 32'h0, 5'd11, 32'hBB, 1'b1);
    tick();
    check("rst.pre.req", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    tick();
    check_all_zero("rst.mid");
    rst = 1'b0;
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    check("rst.post.wbv",  32'(wb_valid), 32'h0);
    check("rst.post.req",  32'(dmem_req), 32'h0);
    check("rst.post.berr", 32'(bus_err),  32'h0);

    // Misaligned load
    drive(1'b1, `MEM_LW_OP, 32'h102, 32'h0, 5'd12, 32'h99, 1'b1);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    check("mis.req",   32'(dmem_req),  32'h0);
    check("mis.stall", 32'(mem_stall), 32'h0);
    check("mis.aerr",  32'(align_err), 32'h1);
    check("mis.wbv",   32'(wb_valid),  32'h1);
    check("mis.we",    32'(wb_we),     32'h0);
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    tick();
    check("mis.after.aerr", 32'(align_err), 32'h0);
`else
    check("mis.req",  32'(dmem_req),  32'h1);
    check("mis.addr", dmem_addr,      32'h102);
    check("mis.aerr", 32'(align_err), 32'h0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h12345678;
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, `MEM_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    check("mis.done.wbv",  32'(wb_valid),  32'h1);
    check("mis.done.data", wb_data,        32'h12345678);
    check("mis.done.aerr", 32'(align_err), 32'h0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
